l2_mem_responder: RTL and testbench

- Memory-side responder for the DL2 cache's external block interface (addrD, enD, weD, doutDstrobe/doutD, dinDstrobe/dinD, readyD, accR, accW).
- Accepts one block read or write at a time and moves the block as 2^SUBLOG2 subblock beats of SUB_W bits.
- Backed by an internal synchronous block store. Serves as the simulation and FPGA-side memory model behind the cache hierarchy.

---
 rtl/l2_mem_responder.sv | 154 +++++++++++++++
 tb/tb_l2_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Memory-side block responder for the DL2 external interface, backed by an internal block store.
// Optional critical-subblock-first reads are enabled by defining MEMRESP_CRIT_FIRST_EN.
module l2_mem_responder #(
  parameter int unsigned ADDR_BITS  = 32,
  parameter int unsigned SUBLOG2    = 3,
  parameter int unsigned SUB_W      = 64,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned READ_LAT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] addrD,
  input  logic                 enD,
  input  logic                 weD,
  input  logic [SUBLOG2-1:0]   doutDstrobe,
  input  logic [SUB_W-1:0]     doutD,
  output logic [SUBLOG2-1:0]   dinDstrobe,
  output logic [SUB_W-1:0]     dinD,
  output logic                 readyD,
  output logic                 accR,
  output logic                 accW
);

  localparam int unsigned N       = 2 ** SUBLOG2;
  localparam int unsigned BLK_OFF = $clog2(N * SUB_W / 8);
  localparam int unsigned LAT_W   = $clog2(READ_LAT + 1);
  localparam int unsigned CNT_W   = SUBLOG2 + 1;
  localparam int unsigned MEM_AW  = DEPTH_LOG2 + SUBLOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_RWAIT, S_RSTREAM, S_WLOAD, S_WDONE, S_DRAIN
  } state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_blk;
  logic [CNT_W-1:0]      r_cnt;
  logic [LAT_W-1:0]      r_lat;
  logic [SUB_W-1:0]      r_mem [2**MEM_AW];

  logic [DEPTH_LOG2-1:0] w_blk_in;
  logic [SUBLOG2-1:0]    w_s0;
  logic [SUBLOG2-1:0]    w_rd_idx;
  logic                  w_emit;
  logic                  w_mem_we;
  logic                  w_unused_addr;

  assign w_blk_in      = addrD[BLK_OFF +: DEPTH_LOG2];
  assign w_unused_addr = ^addrD;

`ifdef MEMRESP_CRIT_FIRST_EN
  logic [SUBLOG2-1:0] r_s0;

  // Starting subblock of a read, captured only on the read-accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0 <= '0;
    end else if (r_state == S_IDLE && !weD && enD) begin
      r_s0 <= addrD[BLK_OFF-1 -: SUBLOG2];
    end
  end
  assign w_s0 = r_s0;
`else
  assign w_s0 = '0;
`endif

  // Beat index wraps naturally modulo N
  assign w_rd_idx = SUBLOG2'(w_s0 + r_cnt[SUBLOG2-1:0]);
  assign w_emit   = (r_state == S_RSTREAM) || (r_state == S_RWAIT && r_lat == '0);
  assign w_mem_we = !reset && (r_state == S_WLOAD) && weD;

  // Block store: not reset, survives aborted transfers
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[{r_blk, doutDstrobe}] <= doutD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_blk      <= '0;
      r_cnt      <= '0;
      r_lat      <= '0;
      readyD     <= 1'b0;
      accR       <= 1'b0;
      accW       <= 1'b0;
      dinDstrobe <= '0;
      dinD       <= '0;
    end else begin
      readyD <= 1'b0;
      accR   <= 1'b0;
      accW   <= 1'b0;

      if (w_emit) begin
        readyD     <= 1'b1;
        dinDstrobe <= w_rd_idx;
        dinD       <= r_mem[{r_blk, w_rd_idx}];
        r_cnt      <= r_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (weD) begin
            r_blk   <= w_blk_in;
            r_cnt   <= '0;
            accW    <= 1'b1;
            r_state <= S_WLOAD;
          end else if (enD) begin
            r_blk   <= w_blk_in;
            r_cnt   <= '0;
            r_lat   <= LAT_W'(READ_LAT - 1);
            accR    <= 1'b1;
            r_state <= S_RWAIT;
          end
        end
        // The edge that finds the counter at zero already emits beat 0
        S_RWAIT: begin
          if (r_lat == '0) begin
            r_state <= S_RSTREAM;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_RSTREAM: begin
          if (r_cnt == CNT_W'(N - 1)) begin
            r_state <= S_DRAIN;
          end
        end
        S_WLOAD: begin
          if (weD) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(N - 1)) begin
              readyD  <= 1'b1;
              r_state <= S_WDONE;
            end
          end
        end
        S_WDONE: begin
          r_state <= S_DRAIN;
        end
        // Held requests must drop before the next one can be accepted
        S_DRAIN: begin
          if (!enD && !weD) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder: a timing-schedule model plus per-cycle compare.
// Expected strobe order follows MEMRESP_CRIT_FIRST_EN when defined.
module tb_l2_mem_responder;

  localparam int READ_LAT = 4;
  localparam int SCHED    = 4096;

  logic        clk;
  logic        reset;
  logic [31:0] addrD;
  logic        enD;
  logic        weD;
  logic [2:0]  doutDstrobe;
  logic [63:0] doutD;
  logic [2:0]  dinDstrobe;
  logic [63:0] dinD;
  logic        readyD;
  logic        accR;
  logic        accW;

  l2_mem_responder #(
    .ADDR_BITS(32), .SUBLOG2(3), .SUB_W(64), .DEPTH_LOG2(12), .READ_LAT(READ_LAT)
  ) dut (
    .clk(clk), .reset(reset), .addrD(addrD), .enD(enD), .weD(weD),
    .doutDstrobe(doutDstrobe), .doutD(doutD), .dinDstrobe(dinDstrobe), .dinD(dinD),
    .readyD(readyD), .accR(accR), .accW(accW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output per edge: value seen in the cycle following edge e
  bit          exp_accR [SCHED];
  bit          exp_accW [SCHED];
  bit          exp_rdy  [SCHED];
  bit          exp_dchk [SCHED];
  logic [2:0]  exp_strb [SCHED];
  logic [63:0] exp_data [SCHED];

  logic [63:0] model_mem [int];
  logic [2:0]  ws [16];
  logic [63:0] wd [16];
  bit          wg [16];

  int          edge_n = 0;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  bit          chk_on = 1'b0;
  logic [2:0]  got_order [$];
  logic [63:0] got_data  [8];
  int          crit_first;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (chk_on && edge_n < SCHED) begin
      n_cmp++;
      if (accR !== exp_accR[edge_n] || accW !== exp_accW[edge_n] || readyD !== exp_rdy[edge_n]) begin
        n_bad++;
        $display("FAIL flags edge %0d: got accR=%b accW=%b readyD=%b want accR=%b accW=%b readyD=%b",
                 edge_n, accR, accW, readyD, exp_accR[edge_n], exp_accW[edge_n], exp_rdy[edge_n]);
      end
      if (exp_dchk[edge_n]) begin
        n_cmp++;
        if (dinDstrobe !== exp_strb[edge_n] || dinD !== exp_data[edge_n]) begin
          n_bad++;
          $display("FAIL beat edge %0d: got strobe=%0d data=%h want strobe=%0d data=%h",
                   edge_n, dinDstrobe, dinD, exp_strb[edge_n], exp_data[edge_n]);
        end
        if (readyD === 1'b1) begin
          got_order.push_back(dinDstrobe);
          got_data[dinDstrobe] = dinD;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic int blk_of(input logic [31:0] a);
    return int'((a >> 6) % 4096);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Write using entries ws/wd/wg[0..nent-1]; gap entries drop weD and must not count
  task automatic do_write(input logic [31:0] a, input int nent, input int hold, input bit with_en);
    int e0, blk, cnt;
    cnt = 0;
    @(posedge clk); #1;
    addrD = a; weD = 1'b1; enD = with_en;
    e0 = edge_n + 1;
    blk = blk_of(a);
    exp_accW[e0] = 1'b1;
    for (int i = 0; i < nent; i++) begin
      @(posedge clk); #1;
      addrD = $urandom;
      weD = !wg[i];
      doutDstrobe = ws[i];
      doutD = wg[i] ? {$urandom, $urandom} : wd[i];
      if (!wg[i]) begin
        model_mem[blk * 8 + int'(ws[i])] = wd[i];
        cnt++;
        if (cnt == 8) exp_rdy[edge_n + 1] = 1'b1;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      weD = 1'b1;
      doutD = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    weD = 1'b0; enD = 1'b0;
    idle_cycles(2);
  endtask

  // Read; rst_beat >= 0 asserts reset during that beat's cycle
  task automatic do_read(input logic [31:0] a, input int rst_beat);
    int e0, blk, s0, e, last;
    @(posedge clk); #1;
    addrD = a; enD = 1'b1; weD = 1'b0;
    e0 = edge_n + 1;
    blk = blk_of(a);
    s0 = crit_first ? int'((a >> 3) & 7) : 0;
    exp_accR[e0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = e0 + READ_LAT + k;
      exp_rdy[e]  = 1'b1;
      exp_dchk[e] = 1'b1;
      exp_strb[e] = 3'((s0 + k) % 8);
      exp_data[e] = model_mem[blk * 8 + (s0 + k) % 8];
    end
    got_order.delete();
    @(posedge clk); #1;
    addrD = $urandom;
    last = (rst_beat >= 0) ? e0 + READ_LAT + rst_beat : e0 + READ_LAT + 7;
    while (edge_n < last) begin
      @(posedge clk); #1;
    end
    if (rst_beat >= 0) begin
      reset = 1'b1; enD = 1'b0;
      for (int i = last + 1; i < SCHED; i++) begin
        exp_accR[i] = 1'b0; exp_accW[i] = 1'b0; exp_rdy[i] = 1'b0; exp_dchk[i] = 1'b0;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      check("reset_readyD", {63'd0, readyD}, 64'd0);
      check("reset_accR", {63'd0, accR}, 64'd0);
      check("reset_dinD", dinD, 64'd0);
      check("reset_strobe", {61'd0, dinDstrobe}, 64'd0);
    end else begin
      enD = 1'b0;
    end
    idle_cycles(2);
  endtask

  task automatic fill_seq(input logic [63:0] base, input bit reverse);
    for (int k = 0; k < 8; k++) begin
      ws[k] = reverse ? 3'(7 - k) : 3'(k);
      wd[k] = base | 64'(reverse ? 7 - k : k);
      wg[k] = 1'b0;
    end
  endtask

  initial begin
`ifdef MEMRESP_CRIT_FIRST_EN
    crit_first = 1;
`else
    crit_first = 0;
`endif
    reset = 1'b1; enD = 1'b0; weD = 1'b0; addrD = '0; doutDstrobe = '0; doutD = '0;
    idle_cycles(3);
    check("init_readyD", {63'd0, readyD}, 64'd0);
    check("init_accR", {63'd0, accR}, 64'd0);
    check("init_accW", {63'd0, accW}, 64'd0);
    check("init_dinD", dinD, 64'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    // Write then read block 1
    fill_seq(64'h1111_0000_0000_0000, 1'b0);
    do_write(32'h0000_0040, 8, 0, 1'b0);
    do_read(32'h0000_0040, -1);
    check("rd1_count", 64'(got_order.size()), 64'd8);
    check("rd1_data2", got_data[2], 64'h1111_0000_0000_0002);
    check("rd1_data7", got_data[7], 64'h1111_0000_0000_0007);

    // Descending strobes into block 2
    fill_seq(64'h2222_0000_0000_0000, 1'b1);
    do_write(32'h0000_0080, 8, 0, 1'b0);
    do_read(32'h0000_0080, -1);
    check("rd2_data0", got_data[0], 64'h2222_0000_0000_0000);
    check("rd2_data6", got_data[6], 64'h2222_0000_0000_0006);

    // Block 3: full preload, then a write with strobe 2 repeated
    fill_seq(64'h3333_0000_0000_0000, 1'b0);
    do_write(32'h0000_00C0, 8, 0, 1'b0);
    ws[0] = 3'd2; wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    ws[1] = 3'd2; wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    ws[2] = 3'd0; wd[2] = 64'h3333_1111_0000_0000;
    ws[3] = 3'd1; wd[3] = 64'h3333_1111_0000_0001;
    ws[4] = 3'd3; wd[4] = 64'h3333_1111_0000_0003;
    ws[5] = 3'd4; wd[5] = 64'h3333_1111_0000_0004;
    ws[6] = 3'd5; wd[6] = 64'h3333_1111_0000_0005;
    ws[7] = 3'd6; wd[7] = 64'h3333_1111_0000_0006;
    do_write(32'h0000_00C0, 8, 0, 1'b0);
    do_read(32'h0000_00C0, -1);
    check("dup_data2", got_data[2], 64'hBBBB_BBBB_BBBB_BBBB);
    check("dup_data7", got_data[7], 64'h3333_0000_0000_0007);

    // enD and weD together, weD held after completion
    fill_seq(64'h4444_0000_0000_0000, 1'b0);
    do_write(32'h0000_0100, 8, 3, 1'b1);
    do_read(32'h0000_0100, -1);
    check("simul_data5", got_data[5], 64'h4444_0000_0000_0005);

    // Index wrap with a 2-cycle weD gap mid-burst
    for (int i = 0; i < 10; i++) begin
      int k;
      k = (i < 4) ? i : i - 2;
      wg[i] = (i == 4 || i == 5);
      ws[i] = 3'(k);
      wd[i] = 64'h5555_0000_0000_0000 | 64'(k);
    end
    do_write(32'h0004_0140, 10, 0, 1'b0);
    do_read(32'h0000_0140, -1);
    check("wrap_data4", got_data[4], 64'h5555_0000_0000_0004);
    check("wrap_data3", got_data[3], 64'h5555_0000_0000_0003);

    // Read of block 1 with subblock offset 5
    do_read(32'h0000_0068, -1);
    check("crit_first", {61'd0, got_order[0]}, crit_first ? 64'd5 : 64'd0);
    check("crit_fourth", {61'd0, got_order[3]}, crit_first ? 64'd0 : 64'd3);
    check("crit_data5", got_data[5], 64'h1111_0000_0000_0005);

    // Reset during beat 3, then a full read
    do_read(32'h0000_0080, 3);
    check("abort_beats", 64'(got_order.size()), 64'd4);
    do_read(32'h0000_0080, -1);
    check("post_rst_count", 64'(got_order.size()), 64'd8);
    check("post_rst_data4", got_data[4], 64'h2222_0000_0000_0004);

    idle_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
